cp0_ctrl: RTL and testbench

Coprocessor-0 block for the pipelined MIPS CPU: the receiving end of the interrupt path that the timers and the external `interrupt` pin drive through the 6-bit `HWInt` bus. Each cycle it combines pending hardware interrupts with the exception code reported by the pipeline and the SR mask bits, and raises a single `req` when the pipeline must flush and jump to the handler. On every taken request it captures the victim PC, branch-delay flag and cause into EPC/Cause. It serves `mfc0`/`mtc0` reads and writes and clears EXL on `eret`.

---
 rtl/cp0_ctrl.sv | 97 +++++++++
 tb/tb_cp0_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - coprocessor-0 interrupt/exception control with SR, Cause, EPC and PRId
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h2001_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  // Cause fields
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  // EPC is word aligned, so only the upper 30 bits are stored
  logic [29:0] epc_word;

  logic        int_req;
  logic        exc_req;
  logic [29:0] victim_word;
  logic        unused_vpc_low;

  // Low PC bits never reach EPC; the branch-delay adjustment is a one-word step back
  assign unused_vpc_low = ^vpc[1:0];

  // Request decode and victim word address, all combinational from current SR
  always_comb begin
    int_req     = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    exc_req     = (exc_code_in != 5'd0) & ~sr_exl;
    req         = int_req | exc_req;
    victim_word = bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2];
  end

  // Register update: request capture beats mtc0 and eret; IP always tracks the lines
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_word  <= 30'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? 5'd0 : exc_code_in;
        epc_word  <= victim_word;
      end else begin
        if (we && cp0_addr == ADDR_SR) begin
          sr_im  <= cp0_wdata[15:10];
          sr_ie  <= cp0_wdata[0];
          sr_exl <= exl_clr ? 1'b0 : cp0_wdata[1];
        end else if (exl_clr) begin
          sr_exl <= 1'b0;
        end
        if (we && cp0_addr == ADDR_EPC) begin
          epc_word <= cp0_wdata[31:2];
        end
      end
    end
  end

  // Read mux returns pre-edge contents; no bypass from same-cycle writes
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      ADDR_CAUSE: cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      ADDR_EPC:   cp0_rdata = {epc_word, 2'b00};
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
    epc_out = {epc_word, 2'b00};
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - self-checking bench for cp0_ctrl against a register-level model
module tb_cp0_ctrl;

  localparam logic [31:0] PRID_VAL = 32'h2001_0707;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exc;
  logic [5:0]  hw;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  int n_pass;
  int n_total;

  // Model state kept as whole architectural words
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_ctrl #(.PRID(PRID_VAL)) dut (
    .clk(clk),
    .reset(rst),
    .we(we),
    .cp0_addr(addr),
    .cp0_wdata(wdata),
    .cp0_rdata(rdata),
    .vpc(vpc),
    .bd_in(bd),
    .exc_code_in(exc),
    .hw_int(hw),
    .exl_clr(exl_clr),
    .req(req),
    .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  function automatic logic m_int_req();
    return ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((exc != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: compute model next state from the inputs, then land on the falling edge
  task automatic tick();
    logic [31:0] n_sr, n_cause, n_epc;
    n_sr = m_sr;
    n_cause = m_cause;
    n_epc = m_epc;
    n_cause[15:10] = hw;
    if (m_req()) begin
      n_sr[1] = 1'b1;
      n_cause[31] = bd;
      n_cause[6:2] = m_int_req() ? 5'd0 : exc;
      n_epc = (bd ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;
    end else begin
      if (we && addr == 5'd12) begin
        n_sr = wdata & 32'h0000_FC03;
        if (exl_clr) n_sr[1] = 1'b0;
      end else if (exl_clr) begin
        n_sr[1] = 1'b0;
      end
      if (we && addr == 5'd14) n_epc = wdata & 32'hFFFF_FFFC;
    end
    if (!rst) begin
      n_sr = 32'd0;
      n_cause = 32'd0;
      n_epc = 32'd0;
    end
    @(posedge clk);
    m_sr = n_sr;
    m_cause = n_cause;
    m_epc = n_epc;
    @(negedge clk);
  endtask

  task automatic quiet();
    we = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'd0;
    bd = 1'b0; exc = 5'd0; hw = 6'd0; exl_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      we = 1'($urandom); addr = 5'($urandom); wdata = $urandom; vpc = $urandom;
      bd = 1'($urandom); exc = 5'($urandom); hw = 6'($urandom); exl_clr = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    quiet();
    for (int a = 12; a <= 15; a++) begin
      addr = 5'(a);
      #1;
      n_total++;
      if (rdata !== ((a == 15) ? PRID_VAL : 32'd0))
        $display("FAIL reset_read addr=%0d got %h want %h", a, rdata, (a == 15) ? PRID_VAL : 32'd0);
      else n_pass++;
    end
    n_total++;
    if (req !== 1'b0) $display("FAIL reset_req got %b want 0", req); else n_pass++;
    n_total++;
    if (epc_out !== 32'd0) $display("FAIL reset_epc got %h want 0", epc_out); else n_pass++;
  endtask

  task automatic test_interrupt();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    tick();
    we = 1'b0; hw = 6'b000001; vpc = 32'h0000_3010; bd = 1'b0;
    #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL int_req got %b want 1", req); else n_pass++;
    tick();
    hw = 6'd0;
    addr = 5'd14;
    #1;
    n_total++;
    if (rdata !== 32'h0000_3010) $display("FAIL int_epc got %h want 00003010", rdata); else n_pass++;
    addr = 5'd13;
    #1;
    n_total++;
    if (rdata[6:2] !== 5'd0) $display("FAIL int_exccode got %0d want 0", rdata[6:2]); else n_pass++;
    addr = 5'd12;
    #1;
    n_total++;
    if (rdata !== 32'h0000_0403) $display("FAIL int_sr got %h want 00000403", rdata); else n_pass++;
    n_total++;
    if (req !== 1'b0) $display("FAIL int_req_after got %b want 0", req); else n_pass++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_exception();
    hw = 6'd0; exc = 5'd10; bd = 1'b1; vpc = 32'h0000_3020;
    #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL exc_req got %b want 1", req); else n_pass++;
    tick();
    exc = 5'd0; bd = 1'b0;
    n_total++;
    #1;
    if (epc_out !== 32'h0000_301C) $display("FAIL exc_epc got %h want 0000301c", epc_out); else n_pass++;
    addr = 5'd13;
    #1;
    n_total++;
    if (rdata !== 32'h8000_0028) $display("FAIL exc_cause got %h want 80000028", rdata); else n_pass++;
  endtask

  task automatic test_exl_mask();
    hw = 6'b000010; exc = 5'd4;
    #1;
    n_total++;
    if (req !== 1'b0) $display("FAIL exl_mask_req got %b want 0", req); else n_pass++;
    tick();
    hw = 6'd0; exc = 5'd0; addr = 5'd13;
    #1;
    n_total++;
    if (rdata !== 32'h8000_0828) $display("FAIL exl_mask_cause got %h want 80000828", rdata); else n_pass++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_req_wins_write();
    hw = 6'b000001; vpc = 32'h0000_4444; bd = 1'b0;
    we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF; exl_clr = 1'b1;
    #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL wins_req got %b want 1", req); else n_pass++;
    tick();
    we = 1'b0; exl_clr = 1'b0;
    #1;
    n_total++;
    if (epc_out !== 32'h0000_4444) $display("FAIL wins_epc got %h want 00004444", epc_out); else n_pass++;
    addr = 5'd12;
    #1;
    n_total++;
    if (rdata[1] !== 1'b1) $display("FAIL wins_exl got %b want 1", rdata[1]); else n_pass++;
  endtask

  task automatic test_eret();
    hw = 6'b000001;
    #1;
    n_total++;
    if (req !== 1'b0) $display("FAIL eret_pre_req got %b want 0", req); else n_pass++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0; addr = 5'd12;
    #1;
    n_total++;
    if (rdata[1] !== 1'b0) $display("FAIL eret_exl got %b want 0", rdata[1]); else n_pass++;
    n_total++;
    if (req !== 1'b1) $display("FAIL eret_pending_req got %b want 1", req); else n_pass++;
    vpc = 32'h0000_5000;
    tick();
    hw = 6'd0;
  endtask

  task automatic test_sr_write_with_eret();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03; exl_clr = 1'b1;
    #1;
    n_total++;
    if (req !== 1'b0) $display("FAIL srw_req got %b want 0", req); else n_pass++;
    tick();
    we = 1'b0; exl_clr = 1'b0;
    #1;
    n_total++;
    if (rdata !== 32'h0000_FC01) $display("FAIL srw_sr got %h want 0000fc01", rdata); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      we = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      wdata = $urandom;
      vpc = $urandom;
      bd = 1'($urandom);
      exc = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      exl_clr = ($urandom_range(0, 5) == 0);
      #1;
      n_total++;
      if (req !== m_req()) $display("FAIL rnd_req cyc=%0d got %b want %b", i, req, m_req()); else n_pass++;
      n_total++;
      if (rdata !== m_read(addr))
        $display("FAIL rnd_rdata cyc=%0d addr=%0d got %h want %h", i, addr, rdata, m_read(addr));
      else n_pass++;
      n_total++;
      if (epc_out !== m_epc) $display("FAIL rnd_epc cyc=%0d got %h want %h", i, epc_out, m_epc); else n_pass++;
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_pass = 0;
    n_total = 0;
    m_sr = 32'd0;
    m_cause = 32'd0;
    m_epc = 32'd0;
    quiet();
    @(negedge clk);
    test_reset();
    test_interrupt();
    test_exception();
    test_exl_mask();
    test_req_wins_write();
    test_eret();
    test_sr_write_with_eret();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
